score_bin2bcd: RTL
==================

Name: score_bin2bcd

Overview:
- Upstream feeder for the four-digit seven-segment multiplexer.
- Converts the binary game score into four BCD digits (d3..d0) using a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Digit outputs are registered and update atomically only when a conversion completes, so the display never shows intermediate values.
- Optional leading-zero blanking drives code 4'hF, which the display encoder renders as blank.

Parameters:
- BIN_W, 14, width of the binary input. 14 bits covers 0..16383.
- MAX_VAL, 9999, saturation ceiling. Inputs above it are clamped.
- BLANK_LZ, 1, when 1, leading zero digits on d3..d1 output 4'hF. d0 is never blanked.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high; one clock domain only
- bin  input  BIN_W  binary score, sampled only on an accepted start
- start  input  1  conversion request, accepted only in IDLE
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse when new digits are valid
- ovf  output  1  registered with the digits; 1 if the last accepted bin exceeded MAX_VAL
- d3  output  4  thousands digit or 4'hF
- d2  output  4  hundreds digit or 4'hF
- d1  output  4  tens digit or 4'hF
- d0  output  4  ones digit, always 0..9

Behaviour:
- Reset (async assert, released synchronously to clk by the top level):
  - state=IDLE, busy=0, done=0, ovf=0, internal shift/BCD registers=0, iteration counter=0.
  - d0=0. d3..d1=4'hF if BLANK_LZ=1, else 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, capture val = (bin > MAX_VAL) ? MAX_VAL : bin, and ovf_next = (bin > MAX_VAL).
  - Clear the 16-bit BCD accumulator, set count=BIN_W-1, go to SHIFT.
  - If start=0, remain in IDLE.
- SHIFT, one iteration per clock:
  - For each accumulator nibble >= 5, add 3 to that nibble (4-bit add, no carry between nibbles).
  - Then shift {accumulator, val} left by 1.
  - If count==0, go to DONE; else decrement count.
  - Exactly BIN_W SHIFT cycles are performed.
- DONE, one cycle:
  - Load d3..d0 from the accumulator, applying blanking, and load ovf.
  - Assert done=1, return to IDLE.
- Blanking (BLANK_LZ=1):
  - d3=F if its digit is 0.
  - d2=F if d3 and d2 digits are both 0.
  - d1=F if d3, d2 and d1 digits are all 0.
- Latency: start sampled high at edge N gives done=1 in the cycle following edge N+BIN_W+1. That is BIN_W+2 edges from request to digits valid; with BIN_W=14, done asserts 16 cycles after the request.
- busy is a registered output: 1 in SHIFT and DONE, 0 in IDLE.
- start while busy=1, including the DONE cycle, is ignored and not queued. The requester must wait for busy=0.
- bin changing during a conversion has no effect; only the captured value is converted.
- d3..d0 and ovf hold their previous values for the whole conversion.
- Reset asserted mid-conversion aborts immediately to reset values; no done pulse is generated.
- Accumulator width is 16 bits, which is sufficient because val <= 9999. No overflow is possible after clamping.
- Simultaneous rst and start: rst wins.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release. Expect d3..d0=F,F,F,0, busy=0, done=0, ovf=0, and no change over 20 idle cycles.
- Basic conversion: bin=1234, start pulse. Expect busy=1 for 15 cycles, done=1 exactly 16 cycles after the request, then d3..d0=1,2,3,4, ovf=0, busy=0 the cycle after done.
- Blanking: bin=7 gives F,F,F,7. bin=50 gives F,F,5,0. bin=0 gives F,F,F,0. bin=9000 gives 9,0,0,0. Repeat with BLANK_LZ=0: bin=7 gives 0,0,0,7.
- Saturation: bin=16383 gives 9,9,9,9 with ovf=1. A following conversion of bin=9999 gives 9,9,9,9 with ovf=0. bin=10000 gives 9,9,9,9 with ovf=1.
- Handshake: convert 42, and while busy pulse start with bin=99 and change bin to 555. Expect exactly one done, result F,F,4,2. Outputs hold prior values until done.
- Reset mid-operation: start bin=8888, assert rst at cycle 6. Expect immediate reset values and no done. Then convert 321 normally to get F,3,2,1.

Source files
------------

// File: rtl/score_bin2bcd.sv
// score_bin2bcd
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock)
// feeding the four-digit seven-segment multiplexer. Inputs above MAX_VAL are
// clamped. Digits are registered and change only when a conversion completes.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   bin    binary score, sampled only when start is accepted in IDLE
//   start  conversion request, ignored unless idle
//   busy   high from the cycle after acceptance through the DONE cycle
//   done   one-cycle pulse when d3..d0 / ovf carry a new result
//   ovf    last accepted bin exceeded MAX_VAL (updated with the digits)
//   d3..d0 thousands..ones digits; d3..d1 read 4'hF when blanked
module score_bin2bcd #(
    parameter int BIN_W    = 14,
    parameter int MAX_VAL  = 9999,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0
);

    localparam int               CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);
    localparam logic [3:0]       RST_D = (BLANK_LZ != 0) ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [15:0]       acc;
    logic [BIN_W-1:0]  val;
    logic [CNT_W-1:0]  count;
    logic              ovf_pend;

    logic              over;
    logic [15:0]       adj;
    logic [3:0]        bd3, bd2, bd1;
    logic              z3, z2, z1;

    assign over = (bin > MAX_V);

    // Add-3 correction applied per nibble before each shift; nibbles are
    // independent (no carry between digits).
    always_comb begin
        adj = acc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Leading-zero blanking cascades from the most significant digit down;
    // the ones digit is always shown.
    always_comb begin
        z3  = (acc[15:12] == 4'd0);
        z2  = (acc[11:8]  == 4'd0);
        z1  = (acc[7:4]   == 4'd0);
        bd3 = acc[15:12];
        bd2 = acc[11:8];
        bd1 = acc[7:4];
        if (BLANK_LZ != 0) begin
            if (z3)             bd3 = 4'hF;
            if (z3 && z2)       bd2 = 4'hF;
            if (z3 && z2 && z1) bd1 = 4'hF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            acc      <= '0;
            val      <= '0;
            count    <= '0;
            d3       <= RST_D;
            d2       <= RST_D;
            d1       <= RST_D;
            d0       <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        val      <= over ? MAX_V : bin;
                        ovf_pend <= over;
                        acc      <= '0;
                        count    <= CNT_W'(BIN_W - 1);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {acc, val} shifted left by one after correction.
                    acc <= {adj[14:0], val[BIN_W-1]};
                    val <= {val[BIN_W-2:0], 1'b0};
                    if (count == '0)
                        state <= DONE;
                    else
                        count <= count - 1'b1;
                end
                DONE: begin
                    d3    <= bd3;
                    d2    <= bd2;
                    d1    <= bd1;
                    d0    <= acc[3:0];
                    ovf   <= ovf_pend;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
